// File: rtl/hpm_counter_bank.sv
// Machine-mode counter bank: mcycle, minstret, mhpmcounters, event selectors
// and mcountinhibit behind one 32-bit CSR port, with sticky overflow flags.
module hpm_counter_bank #(
  parameter int NUM_HPM       = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_wen,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_hit,
  input  logic                  inst_retired,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  ovf_irq
);

  localparam int CW = COUNTER_WIDTH;
  localparam int S  = $clog2(NUM_EVENTS + 1);
  localparam int EW = 1 << S;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [S-1:0]  sel_t;

  // Slot i holds CSR number i: 0=cycle, 2=instret, 3..=hpm
  cnt_t        cnt_q [32];
  cnt_t        cnt_d [32];
  sel_t        sel_q [32];
  sel_t        sel_d [32];
  logic [31:0] of_q, of_d;
  logic [31:0] inh_q, inh_d;
  logic [31:0] impl, inc, lo_wr, hi_wr, ev_wr, wrap;
  logic [EW-1:0] ev_ext;
  logic [4:0]  idx;
  logic        lo_hit, hi_hit, ev_blk, ev_hit;

  for (genvar g = 0; g < 32; g++) begin : g_impl
    assign impl[g] = (g == 0) || (g == 2) ||
                     ((g >= 3) && (g < 3 + NUM_HPM));
  end

  assign idx    = csr_addr[4:0];
  assign lo_hit = csr_addr[11:5] == 7'h58;
  assign hi_hit = csr_addr[11:5] == 7'h5C;
  assign ev_blk = csr_addr[11:5] == 7'h19;
  assign ev_hit = ev_blk && (idx == 5'd0 || idx >= 5'd3);
  assign csr_hit = lo_hit | hi_hit | ev_hit;
  assign ev_ext  = EW'({events, 1'b0});
  assign ovf_irq = |of_q;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      lo_wr[i] = csr_wen && lo_hit && idx == 5'(i);
      hi_wr[i] = csr_wen && hi_hit && idx == 5'(i);
      ev_wr[i] = csr_wen && ev_hit && idx == 5'(i) && i >= 3;
      if (i == 0)      inc[i] = 1'b1;
      else if (i == 2) inc[i] = inst_retired;
      else if (i >= 3) inc[i] = (sel_q[i] != '0) && ev_ext[sel_q[i]];
      else             inc[i] = 1'b0;
      inc[i]  = inc[i] && impl[i] && !inh_q[i] && !lo_wr[i] && !hi_wr[i];
      wrap[i] = inc[i] && (&cnt_q[i]);
    end
  end

  always_comb begin
    inh_d = inh_q;
    if (csr_wen && ev_hit && idx == 5'd0)
      inh_d = csr_wdata & impl;
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(inc[i]);
      sel_d[i] = sel_q[i];
      of_d[i]  = of_q[i];
      if (lo_wr[i]) cnt_d[i] = {cnt_q[i][CW-1:32], csr_wdata};
      if (hi_wr[i]) cnt_d[i] = {csr_wdata[CW-33:0], cnt_q[i][31:0]};
      if (ev_wr[i]) begin
        sel_d[i] = (int'(csr_wdata[S-1:0]) > NUM_EVENTS) ?
                   '0 : csr_wdata[S-1:0];
        of_d[i]  = csr_wdata[31];
      end
      // Hardware overflow beats a same-cycle software clear
      if (wrap[i] && i >= 3) of_d[i] = 1'b1;
      if (!impl[i]) begin
        cnt_d[i] = '0;
        sel_d[i] = '0;
        of_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      of_q  <= '0;
      inh_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      of_q  <= of_d;
      inh_q <= inh_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (lo_hit)
      csr_rdata = cnt_q[idx][31:0];
    else if (hi_hit)
      csr_rdata = 32'(cnt_q[idx][CW-1:32]);
    else if (ev_hit) begin
      if (idx == 5'd0) csr_rdata = inh_q;
      else csr_rdata = {of_q[idx], 31'(sel_q[idx])};
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank with default parameters
// (NUM_HPM=4, COUNTER_WIDTH=64, NUM_EVENTS=8).
module tb_hpm_counter_bank;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        inst_retired;
  logic [7:0]  events;
  logic        ovf_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  hpm_counter_bank dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .csr_addr     (csr_addr),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_hit      (csr_hit),
    .inst_retired (inst_retired),
    .events       (events),
    .ovf_irq      (ovf_irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_addr = a;
    #1;
    v = csr_rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    csr_addr  = a;
    csr_wdata = v;
    csr_wen   = 1'b1;
    tick(1);
    csr_wen   = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; csr_addr = '0; csr_wen = 1'b0; csr_wdata = '0;
    inst_retired = 1'b0; events = '0;
    tick(3);
    rd(12'hB00, d); chk("rst_mcycle", d, 32'd0);
    chk("rst_ovf", 32'(ovf_irq), 32'd0);

    // 1: five free cycles
    nRST = 1'b1;
    tick(5);
    rd(12'hB00, d); chk("t1_mcycle", d, 32'd5);
    chk("t1_hit", 32'(csr_hit), 32'd1);
    rd(12'hB02, d); chk("t1_minstret", d, 32'd0);
    rd(12'h323, d); chk("t1_evt3", d, 32'd0);
    chk("t1_ovf", 32'(ovf_irq), 32'd0);

    // 2: inhibit cycle counter
    wr(12'h320, 32'h1);
    tick(10);
    rd(12'hB00, d); chk("t2_frozen", d, 32'd6);
    rd(12'h320, d); chk("t2_inh", d, 32'h1);
    wr(12'h320, 32'h0);
    rd(12'hB00, d); chk("t2_still", d, 32'd6);
    tick(1);
    rd(12'hB00, d); chk("t2_resume", d, 32'd7);
    inst_retired = 1'b1;
    tick(3);
    inst_retired = 1'b0;
    rd(12'hB02, d); chk("t2_minstret", d, 32'd3);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, d); chk("t2_inh_mask", d, 32'h7D);
    wr(12'h320, 32'h0);

    // 3: event select
    wr(12'h323, 32'd2);
    rd(12'h323, d); chk("t3_sel", d, 32'd2);
    events = 8'h02;
    tick(7);
    events = 8'h00;
    rd(12'hB03, d); chk("t3_cnt", d, 32'd7);
    wr(12'h323, 32'd9);
    rd(12'h323, d); chk("t3_sel_warl", d, 32'd0);
    events = 8'h02;
    tick(3);
    events = 8'h00;
    rd(12'hB03, d); chk("t3_stopped", d, 32'd7);
    wr(12'h324, 32'd8);
    rd(12'h324, d); chk("t3_sel_max", d, 32'd8);
    events = 8'h80;
    tick(2);
    events = 8'h00;
    rd(12'hB04, d); chk("t3_cnt4", d, 32'd2);

    // 4: wrap and overflow
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    rd(12'hB03, d); chk("t4_lo_ones", d, 32'hFFFF_FFFF);
    rd(12'hB83, d); chk("t4_hi_ones", d, 32'hFFFF_FFFF);
    wr(12'h323, 32'd1);
    chk("t4_ovf_pre", 32'(ovf_irq), 32'd0);
    events = 8'h01;
    tick(1);
    events = 8'h00;
    rd(12'hB03, d); chk("t4_lo_wrap", d, 32'd0);
    rd(12'hB83, d); chk("t4_hi_wrap", d, 32'd0);
    rd(12'h323, d); chk("t4_of", d, 32'h8000_0001);
    chk("t4_ovf", 32'(ovf_irq), 32'd1);
    wr(12'h323, 32'd1);
    rd(12'h323, d); chk("t4_of_clr", d, 32'h1);
    chk("t4_ovf_clr", 32'(ovf_irq), 32'd0);

    // 5: write beats increment
    rd(12'hB80, d); chk("t5_hi_pre", d, 32'd0);
    wr(12'hB00, 32'h10);
    rd(12'hB00, d); chk("t5_lo", d, 32'h10);
    rd(12'hB80, d); chk("t5_hi", d, 32'd0);
    tick(1);
    rd(12'hB00, d); chk("t5_lo_inc", d, 32'h11);
    wr(12'hB80, 32'd5);
    rd(12'hB00, d); chk("t5_lo_keep", d, 32'h11);
    rd(12'hB80, d); chk("t5_hi_wr", d, 32'd5);

    // 6: unimplemented but decoded addresses
    rd(12'hB07, d); chk("t6_b07", d, 32'd0);
    chk("t6_b07_hit", 32'(csr_hit), 32'd1);
    wr(12'hB07, 32'hDEAD_BEEF);
    tick(1);
    rd(12'hB07, d); chk("t6_b07_after", d, 32'd0);
    rd(12'hB01, d); chk("t6_b01", d, 32'd0);
    chk("t6_b01_hit", 32'(csr_hit), 32'd1);
    wr(12'hB01, 32'h1234_5678);
    rd(12'hB01, d); chk("t6_b01_after", d, 32'd0);
    wr(12'h33F, 32'h8000_0003);
    rd(12'h33F, d); chk("t6_evt31", d, 32'd0);
    chk("t6_evt31_hit", 32'(csr_hit), 32'd1);
    chk("t6_ovf", 32'(ovf_irq), 32'd0);
    rd(12'h321, d); chk("t6_321_hit", 32'(csr_hit), 32'd0);
    chk("t6_321_data", d, 32'd0);

    // Reset overrides a same-cycle write
    nRST = 1'b0;
    wr(12'hB00, 32'h55);
    nRST = 1'b1;
    rd(12'hB00, d); chk("rst2_mcycle", d, 32'd0);
    rd(12'hB80, d); chk("rst2_hi", d, 32'd0);
    rd(12'h324, d); chk("rst2_sel", d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
